// File: rtl/rightshift_seq_if.sv
// Operand/result handshake bundle for rightshift_seq.
// master = producer/consumer side, slave = the shifter.
interface rightshift_seq_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_cout;

    modport master (
        output in_valid, in_data, in_shamt, in_arith, out_ready,
        input  in_ready, out_valid, out_data, out_cout
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_arith, out_ready,
        output in_ready, out_valid, out_data, out_cout
    );
endinterface

// File: rtl/rightshift_seq.sv
// Sequential right shifter: one bit per clock, IDLE -> SHIFT -> DONE handshake.
// Define RSHIFT_ARITH_EN to honour in_arith (sign fill); otherwise the fill is always 0.
module rightshift_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4   // 2**SHAMT_W must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    rightshift_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   data_reg;
    logic [SHAMT_W-1:0] count_reg;
    logic               cout_reg;
    logic               fill;

`ifdef RSHIFT_ARITH_EN
    logic               arith_reg;
    assign fill = arith_reg & data_reg[WIDTH-1];
`else
    logic               arith_unused;
    assign arith_unused = bus.in_arith;
    assign fill         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            cout_reg  <= 1'b0;
`ifdef RSHIFT_ARITH_EN
            arith_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_reg  <= bus.in_data;
                        count_reg <= bus.in_shamt;
                        cout_reg  <= 1'b0;
`ifdef RSHIFT_ARITH_EN
                        arith_reg <= bus.in_arith;
`endif
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The edge that finds count exhausted only moves to DONE.
                    if (count_reg != '0) begin
                        data_reg  <= {fill, data_reg[WIDTH-1:1]};
                        cout_reg  <= data_reg[0];
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_data  = data_reg;
    assign bus.out_cout  = cout_reg;
endmodule

// File: tb/tb_rightshift_seq.sv
// Directed bench for rightshift_seq: vector table plus backpressure and mid-shift reset sequences.
module tb_rightshift_seq;
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;
`ifdef RSHIFT_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  shamt;
        logic        arith;
        logic [15:0] exp_data;
        logic        exp_cout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [7];

    rightshift_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    rightshift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an operand for exactly one edge; returns after the acceptance edge.
    task automatic start_op(input logic [15:0] d, input logic [3:0] s, input logic a);
        @(negedge clk);
        check("in_ready_before_issue", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_arith = a;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
    endtask

    // Counts edges after acceptance until out_valid rises (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_release", {31'b0, bus.in_ready}, 32'd1);
        check("out_valid_after_release", {31'b0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.data, v.shamt, v.arith);
        wait_done(lat);
        check("latency", lat, 32'(v.shamt) + 32'd1);
        check("out_data", {16'b0, bus.out_data}, {16'b0, v.exp_data});
        check("out_cout", {31'b0, bus.out_cout}, {31'b0, v.exp_cout});
        $display("op data=%h shamt=%0d arith=%0d -> out=%h cout=%0d lat=%0d",
                 v.data, v.shamt, v.arith, bus.out_data, bus.out_cout, lat);
        release_result();
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_arith  = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h8F00, 4'd7,  1'b0, 16'h011E, 1'b0};
        vecs[1] = '{16'hFE00, 4'd7,  1'b1, ARITH ? 16'hFFFC : 16'h01FC, 1'b0};
        vecs[2] = '{16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0};
        vecs[3] = '{16'h8000, 4'd15, 1'b0, 16'h0001, 1'b0};
        vecs[4] = '{16'h0003, 4'd1,  1'b0, 16'h0001, 1'b1};
        vecs[5] = '{16'hA5A5, 4'd3,  1'b1, ARITH ? 16'hF4B4 : 16'h14B4, 1'b1};
        vecs[6] = '{16'h7FFF, 4'd15, 1'b1, 16'h0000, 1'b1};

        // Reset takes effect without a clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_out_data", {16'b0, bus.out_data}, 32'd0);
        check("reset_out_cout", {31'b0, bus.out_cout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // Backpressure: result holds, new operands ignored, release edge accepts nothing.
        start_op(16'h00FF, 4'd4, 1'b0);
        wait_done(lat);
        check("bp_latency", lat, 32'd5);
        held = bus.out_data;
        check("bp_data", {16'b0, held}, 32'h000F);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = 16'hAAAA;
            bus.in_shamt = 4'd0;
            @(posedge clk);
            #1;
            check("bp_hold_data", {16'b0, bus.out_data}, {16'b0, held});
            check("bp_hold_cout", {31'b0, bus.out_cout}, 32'd1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_release_idle", {31'b0, bus.in_ready}, 32'd1);
        check("bp_release_data", {16'b0, bus.out_data}, {16'b0, held});
        $display("backpressure op data=00ff shamt=4 held=%h", held);

        // out_ready held high during SHIFT must not shorten the operation.
        @(negedge clk);
        bus.out_ready = 1'b1;
        start_op(16'h0F0F, 4'd2, 1'b0);
        wait_done(lat);
        check("early_ready_latency", lat, 32'd3);
        check("early_ready_data", {16'b0, bus.out_data}, 32'h03C3);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("early_ready_idle", {31'b0, bus.in_ready}, 32'd1);
        $display("early-ready op data=0f0f shamt=2 lat=%0d", lat);

        // Reset mid-SHIFT abandons the operation.
        start_op(16'hFFFF, 4'd10, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_data", {16'b0, bus.out_data}, 32'd0);
        check("midrst_out_cout", {31'b0, bus.out_cout}, 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.out_valid) lat++;
        end
        check("midrst_no_result", lat, 32'd0);
        $display("mid-shift reset op data=ffff shamt=10 abandoned");

        run_vec('{16'h00F0, 4'd4, 1'b0, 16'h000F, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
